// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared types for the serial magnitude comparator.
// Holds the controller state encoding and the per-chunk verdict record.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Outcome of comparing one operand pair (or one chunk pair).
   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } verdict_t;

endpackage

// File: rtl/serial_cmp_if.sv
// serial_cmp_if: operand/result handshake bundle for serial_cmp.
// master = producer/consumer side, slave = comparator side.
interface serial_cmp_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic         gtu, ltu, geu, leu;
   logic         gts, lts, ges, les;
   logic         eq;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid,
      input  gtu, ltu, geu, leu, gts, lts, ges, les, eq
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid,
      output gtu, ltu, geu, leu, gts, lts, ges, les, eq
   );
endinterface

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational compare of one CW-bit chunk pair.
// Gives the unsigned verdict and, treating the chunks as two's complement,
// the signed verdict (only meaningful for the most significant chunk).
module cmp_chunk
   import serial_cmp_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [CW-1:0] i_a,
   input  logic [CW-1:0] i_b,
   output verdict_t      o_uns,
   output verdict_t      o_sgn
);
   logic signed [CW-1:0] w_sa;
   logic signed [CW-1:0] w_sb;

   assign w_sa = i_a;
   assign w_sb = i_b;

   // Both verdicts derived from the same chunk pair; equality is sign-agnostic.
   always_comb begin
      o_uns.gt = (i_a > i_b);
      o_uns.lt = (i_a < i_b);
      o_uns.eq = (i_a == i_b);
      o_sgn.gt = (w_sa > w_sb);
      o_sgn.lt = (w_sa < w_sb);
      o_sgn.eq = (i_a == i_b);
   end
endmodule

// File: rtl/serial_cmp.sv
// serial_cmp: chunk-serial signed/unsigned magnitude comparator.
// Operands are shifted out MSB chunk first, one chunk per RUN cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish right after the first
// unequal chunk; otherwise latency is fixed at N+1 cycles.
module serial_cmp
   import serial_cmp_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 8
) (
   input logic        clk,
   input logic        rst_n,
   serial_cmp_if.slave bus
);
   localparam int N     = W / CW;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]       r_state;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [IDX_W-1:0] r_idx;
   verdict_t         r_uv;
   verdict_t         r_sv;
   logic             r_fixed;

   verdict_t         w_cu;
   verdict_t         w_cs;
   logic             w_last;
   logic             w_exit;
   logic             w_done;

   // The current chunk is always the top CW bits of the shifting operands.
   cmp_chunk #(.CW(CW)) u_chunk (
      .i_a   (r_a[W-1 -: CW]),
      .i_b   (r_b[W-1 -: CW]),
      .o_uns (w_cu),
      .o_sgn (w_cs)
   );

   assign w_last = (r_idx == IDX_W'(N - 1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_exit = w_last | ~w_cu.eq;
`else
   assign w_exit = w_last;
`endif

   // Controller and datapath: accept, walk the chunks, hold result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_uv    <= '0;
         r_sv    <= '0;
         r_fixed <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_idx   <= '0;
                  r_fixed <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // First unequal chunk decides; the sign only matters on chunk 0.
               if (!r_fixed) begin
                  r_uv    <= w_cu;
                  r_sv    <= (r_idx == '0) ? w_cs : w_cu;
                  r_fixed <= ~w_cu.eq;
               end
               r_a   <= r_a << CW;
               r_b   <= r_b << CW;
               r_idx <= r_idx + IDX_W'(1);
               if (w_exit) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_done        = (r_state == S_DONE);
   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = w_done;

   assign bus.gtu = w_done & r_uv.gt;
   assign bus.ltu = w_done & r_uv.lt;
   assign bus.geu = w_done & (r_uv.gt | r_uv.eq);
   assign bus.leu = w_done & (r_uv.lt | r_uv.eq);
   assign bus.gts = w_done & r_sv.gt;
   assign bus.lts = w_done & r_sv.lt;
   assign bus.ges = w_done & (r_sv.gt | r_sv.eq);
   assign bus.les = w_done & (r_sv.lt | r_sv.eq);
   assign bus.eq  = w_done & r_uv.eq;
endmodule

// File: tb/tb_serial_cmp.sv
// tb_serial_cmp: table-driven bench for serial_cmp (W=32/CW=8 and W=8/CW=8).
// Flag vector order: {gtu,ltu,geu,leu,gts,lts,ges,les,eq}.
module tb_serial_cmp;
   logic clk;
   logic rst_n;

   serial_cmp_if #(.W(32)) bus32 ();
   serial_cmp_if #(.W(8))  bus8 ();

   serial_cmp #(.W(32), .CW(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   serial_cmp #(.W(8),  .CW(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [8:0]  exp;
      int          k;
   } vec_t;

   vec_t       tbl[10];
   logic [8:0] sb_q[$];
   int         tests;
   int         fails;

   function automatic logic [8:0] flags32();
      return {bus32.gtu, bus32.ltu, bus32.geu, bus32.leu,
              bus32.gts, bus32.lts, bus32.ges, bus32.les, bus32.eq};
   endfunction

   function automatic logic [8:0] flags8();
      return {bus8.gtu, bus8.ltu, bus8.geu, bus8.leu,
              bus8.gts, bus8.lts, bus8.ges, bus8.les, bus8.eq};
   endfunction

   function automatic int exp_lat(input int k, input int n);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      return k + 2;
`else
      return n + 1;
`endif
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One transaction on the 32-bit DUT; out_ready held low for 'hold' cycles.
   task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [8:0] exp, input int lat, input int hold);
      int  n;
      bit  seen;
      logic [8:0] e;
      @(negedge clk);
      bus32.a         = a;
      bus32.b         = b;
      bus32.in_valid  = 1'b1;
      bus32.out_ready = (hold == 0);
      check({nm, "_in_ready"}, bus32.in_ready, 1);
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      n    = 0;
      seen = 0;
      while (!seen && n < 20) begin
         if (bus32.out_valid) seen = 1;
         else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      e = sb_q.pop_front();
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no out_valid expected latency %0d", nm, lat);
         return;
      end
      check({nm, "_latency"}, n + 1, lat);
      check({nm, "_flags"}, flags32(), e);
      for (int i = 0; i < hold; i++) begin
         check({nm, "_hold_flags"}, flags32(), e);
         check({nm, "_hold_valid"}, bus32.out_valid, 1);
         check({nm, "_hold_ready"}, bus32.in_ready, 0);
         @(posedge clk);
         #1;
      end
      if (hold > 0) begin
         @(negedge clk);
         bus32.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check({nm, "_drop_valid"}, bus32.out_valid, 0);
      check({nm, "_idle"}, bus32.in_ready, 1);
   endtask

   initial begin
      int  n;
      bit  seen;
      bit  spur;
      logic [8:0] e;
      tests = 0;
      fails = 0;

      tbl[0] = '{32'h8000_0000, 32'h0000_0001, 9'b1010_0101_0, 0};
      tbl[1] = '{32'h1234_5678, 32'h1234_5678, 9'b0011_0011_1, 3};
      tbl[2] = '{32'h1234_5679, 32'h1234_5678, 9'b1010_1010_0, 3};
      tbl[3] = '{32'h0000_0001, 32'h8000_0000, 9'b0101_1010_0, 0};
      tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 9'b1010_0101_0, 0};
      tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 9'b0101_1010_0, 0};
      tbl[6] = '{32'h12FF_0000, 32'h1201_0000, 9'b1010_1010_0, 1};
      tbl[7] = '{32'hFFFF_FF00, 32'hFFFF_FF01, 9'b0101_0101_0, 3};
      tbl[8] = '{32'h8000_0000, 32'h8000_0000, 9'b0011_0011_1, 3};
      tbl[9] = '{32'hFE00_0000, 32'hFF00_0000, 9'b0101_0101_0, 0};

      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", bus32.in_ready, 1);
      check("rst_out_valid", bus32.out_valid, 0);
      check("rst_flags", flags32(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run32($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp,
               exp_lat(tbl[i].k, 4), 0);
      end

      // Result held under backpressure for three cycles.
      run32("bp", 32'h8000_0000, 32'h0000_0001, 9'b1010_0101_0, exp_lat(0, 4), 3);

      // Reset in the second RUN cycle aborts the transaction.
      @(negedge clk);
      bus32.a = 32'h1234_5678;
      bus32.b = 32'h1234_5678;
      bus32.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_in_ready", bus32.in_ready, 1);
      check("abort_out_valid", bus32.out_valid, 0);
      check("abort_flags", flags32(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      spur = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus32.out_valid) spur = 1;
      end
      check("abort_no_pulse", spur, 0);
      run32("after_abort", 32'h1234_5679, 32'h1234_5678, 9'b1010_1010_0, exp_lat(3, 4), 0);

      // Single-chunk build: chunk 0 is the whole operand.
      @(negedge clk);
      bus8.a = 8'hFF;
      bus8.b = 8'h01;
      bus8.in_valid = 1'b1;
      sb_q.push_back(9'b1010_0101_0);
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         if (bus8.out_valid) seen = 1;
         else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      e = sb_q.pop_front();
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL w8_timeout: got no out_valid expected latency 2");
      end else begin
         check("w8_latency", n + 1, 2);
         check("w8_flags", flags8(), e);
         @(posedge clk);
         #1;
         check("w8_drop_valid", bus8.out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule
